// File: rtl/triple_buffer_scheduler_if.sv
// Bank-role handshake between renderer/video timing and the triple-buffer scheduler.
interface triple_buffer_scheduler_if #(
   parameter int ADDR_W = 19
);
   logic              frame_done_in;
   logic              vsync_in;
   logic [1:0]        write_bank_out;
   logic [1:0]        display_bank_out;
   logic [1:0]        clear_bank_out;
   logic [ADDR_W-1:0] clear_addr_out;
   logic              clear_we_out;
   logic              write_ready_out;
   logic              frame_start_out;
   logic [15:0]       swap_count_out;
   logic [7:0]        missed_out;

   modport slave (
      input  frame_done_in, vsync_in,
      output write_bank_out, display_bank_out, clear_bank_out, clear_addr_out,
             clear_we_out, write_ready_out, frame_start_out, swap_count_out, missed_out
   );

   modport master (
      output frame_done_in, vsync_in,
      input  write_bank_out, display_bank_out, clear_bank_out, clear_addr_out,
             clear_we_out, write_ready_out, frame_start_out, swap_count_out, missed_out
   );
endinterface

// File: rtl/triple_buffer_scheduler.sv
// Rotates WRITE/DISPLAY/CLEAR roles across three overlay banks and sweeps the CLEAR bank to zero.
// Optional macro SWAP_STATS_EN enables the rotation and missed-vsync counters.
module triple_buffer_scheduler #(
   parameter int WIDTH  = 480,
   parameter int HEIGHT = 640
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   triple_buffer_scheduler_if.slave    bus
);
   localparam int DEPTH  = WIDTH * HEIGHT;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {RENDER, WAIT_SWAP, SWAP} state_t;

   state_t            state_q;
   logic [1:0]        write_q, display_q, clear_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q, done_q, ready_q, start_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= RENDER;
         write_q   <= 2'd0;
         display_q <= 2'd1;
         clear_q   <= 2'd2;
         addr_q    <= '0;
         we_q      <= 1'b1;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         start_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (we_q) begin
            if (addr_q == LAST_ADDR) begin
               we_q   <= 1'b0;
               addr_q <= '0;
               done_q <= 1'b1;
            end else begin
               addr_q <= addr_q + 1'b1;
            end
         end
         case (state_q)
            RENDER: begin
               if (bus.frame_done_in) begin
                  state_q <= WAIT_SWAP;
                  ready_q <= 1'b0;
               end
            end
            WAIT_SWAP: begin
               if (bus.vsync_in && done_q) begin
                  state_q   <= SWAP;
                  display_q <= write_q;
                  write_q   <= clear_q;
                  clear_q   <= display_q;
                  start_q   <= 1'b1;
               end
            end
            SWAP: begin
               // Sweep is idle during SWAP, so restarting it here overrides nothing.
               state_q <= RENDER;
               ready_q <= 1'b1;
               we_q    <= 1'b1;
               addr_q  <= '0;
               done_q  <= 1'b0;
            end
            default: state_q <= RENDER;
         endcase
      end
   end

`ifdef SWAP_STATS_EN
   logic [15:0] swaps_q;
   logic [7:0]  missed_q;
   logic        miss_evt, swap_evt;

   always_comb begin
      swap_evt = (state_q == WAIT_SWAP) && bus.vsync_in && done_q;
      miss_evt = bus.vsync_in &&
                 ((state_q == RENDER) || ((state_q == WAIT_SWAP) && !done_q));
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         swaps_q  <= '0;
         missed_q <= '0;
      end else begin
         if (swap_evt) swaps_q <= swaps_q + 16'd1;
         if (miss_evt && (missed_q != 8'hFF)) missed_q <= missed_q + 8'd1;
      end
   end

   assign bus.swap_count_out = swaps_q;
   assign bus.missed_out     = missed_q;
`else
   assign bus.swap_count_out = '0;
   assign bus.missed_out     = '0;
`endif

   assign bus.write_bank_out   = write_q;
   assign bus.display_bank_out = display_q;
   assign bus.clear_bank_out   = clear_q;
   assign bus.clear_addr_out   = addr_q;
   assign bus.clear_we_out     = we_q;
   assign bus.write_ready_out  = ready_q;
   assign bus.frame_start_out  = start_q;
endmodule

// File: tb/tb_triple_buffer_scheduler.sv
// Directed table-driven bench for triple_buffer_scheduler at WIDTH=4, HEIGHT=2 (DEPTH=8).
module tb_triple_buffer_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vecs = 0;
   int   fails = 0;

   triple_buffer_scheduler_if #(.ADDR_W(3)) bus ();

   triple_buffer_scheduler #(.WIDTH(4), .HEIGHT(2)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idle;
      bit fd, vs;
      int w, d, c, we, a, r, fs, sw, m;
   } vec_t;

   vec_t tbl [16];

   function automatic int st(input int v);
`ifdef SWAP_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input bit fd, input bit vs);
      bus.frame_done_in = fd;
      bus.vsync_in      = vs;
      @(posedge clk);
      #1;
      bus.frame_done_in = 1'b0;
      bus.vsync_in      = 1'b0;
   endtask

   task automatic chk_all(input string tag, input int w, input int d, input int c, input int we,
                          input int a, input int r, input int fs, input int sw, input int m);
      chk({tag, ".write"},   int'(bus.write_bank_out),   w);
      chk({tag, ".display"}, int'(bus.display_bank_out), d);
      chk({tag, ".clear"},   int'(bus.clear_bank_out),   c);
      chk({tag, ".we"},      int'(bus.clear_we_out),     we);
      chk({tag, ".addr"},    int'(bus.clear_addr_out),   a);
      chk({tag, ".ready"},   int'(bus.write_ready_out),  r);
      chk({tag, ".fstart"},  int'(bus.frame_start_out),  fs);
      chk({tag, ".swaps"},   int'(bus.swap_count_out),   st(sw));
      chk({tag, ".missed"},  int'(bus.missed_out),       st(m));
   endtask

   // Bank indices must always form a permutation of {0,1,2}.
   always @(negedge clk) begin
      if (rst_n) begin
         vecs++;
         if (bus.write_bank_out == bus.display_bank_out || bus.write_bank_out == bus.clear_bank_out ||
             bus.display_bank_out == bus.clear_bank_out || bus.write_bank_out == 2'd3 ||
             bus.display_bank_out == 2'd3 || bus.clear_bank_out == 2'd3) begin
            fails++;
            $display("FAIL perm: got %0d/%0d/%0d expected a permutation of 0,1,2 at %0t",
                     bus.write_bank_out, bus.display_bank_out, bus.clear_bank_out, $time);
         end
      end
   end

   initial begin
      //            idle fd vs   w  d  c we  a  r fs sw  m
      tbl[0]  = '{0, 0, 0,   0, 1, 2, 1, 1, 1, 0, 0, 0};
      tbl[1]  = '{1, 1, 0,   0, 1, 2, 1, 3, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 1,   0, 1, 2, 1, 5, 0, 0, 0, 1};
      tbl[3]  = '{1, 0, 0,   0, 1, 2, 1, 7, 0, 0, 0, 1};
      tbl[4]  = '{0, 0, 0,   0, 1, 2, 0, 0, 0, 0, 0, 1};
      tbl[5]  = '{0, 0, 1,   2, 0, 1, 0, 0, 0, 1, 1, 1};
      tbl[6]  = '{0, 0, 0,   2, 0, 1, 1, 0, 1, 0, 1, 1};
      tbl[7]  = '{0, 1, 1,   2, 0, 1, 1, 1, 0, 0, 1, 2};
      tbl[8]  = '{6, 0, 0,   2, 0, 1, 0, 0, 0, 0, 1, 2};
      tbl[9]  = '{0, 0, 1,   1, 2, 0, 0, 0, 0, 1, 2, 2};
      tbl[10] = '{0, 0, 0,   1, 2, 0, 1, 0, 1, 0, 2, 2};
      tbl[11] = '{0, 0, 1,   1, 2, 0, 1, 1, 1, 0, 2, 3};
      tbl[12] = '{1, 0, 1,   1, 2, 0, 1, 3, 1, 0, 2, 4};
      tbl[13] = '{5, 1, 0,   1, 2, 0, 0, 0, 0, 0, 2, 4};
      tbl[14] = '{0, 0, 1,   0, 1, 2, 0, 0, 0, 1, 3, 4};
      tbl[15] = '{0, 0, 0,   0, 1, 2, 1, 0, 1, 0, 3, 4};

      bus.frame_done_in = 1'b0;
      bus.vsync_in      = 1'b0;
      @(posedge clk);
      #1;
      chk_all("reset", 0, 1, 2, 1, 0, 1, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         repeat (tbl[i].idle) tick(1'b0, 1'b0);
         tick(tbl[i].fd, tbl[i].vs);
         chk_all($sformatf("vec%0d", i), tbl[i].w, tbl[i].d, tbl[i].c, tbl[i].we,
                 tbl[i].a, tbl[i].r, tbl[i].fs, tbl[i].sw, tbl[i].m);
      end

      // Rotate once more so reset has non-default roles to undo.
      tick(1'b1, 1'b0);
      repeat (7) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk_all("swap4", 2, 0, 1, 0, 0, 0, 1, 4, 4);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (4) tick(1'b0, 1'b0);
      chk_all("pre_rst", 2, 0, 1, 1, 5, 0, 0, 4, 4);

      // Async reset mid-cycle: outputs must change before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 1, 2, 1, 0, 1, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(1'b0, 1'b0);
      chk_all("post_rst", 0, 1, 2, 1, 1, 1, 0, 0, 0);

      // Renderer never finishes: display held, missed saturates.
      repeat (300) tick(1'b0, 1'b1);
      chk_all("saturate", 0, 1, 2, 0, 0, 1, 0, 0, 255);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
